logic_operand_stage: RTL and testbench
======================================

# logic_operand_stage

Operand staging and writeback stage wrapped around the 8-bit bitwise logic unit (OR unit, ports `ina`, `inb`, `out`).

- Holds a small register file and issues one logic operation per request.
- Reads two source registers onto `ina`/`inb` and captures the unit's `out`.
- Writes the result back to a destination register, then signals completion.
- Sits directly upstream of the logic unit, which is instantiated externally, and directly downstream of the instruction decoder.

## Interface

Parameters:

- `WIDTH`, 8, datapath width; must match the logic unit.
- `NREG`, 4, number of registers.
- `AW`, 2, register address width; NREG = 2^AW.

Ports:

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoder presents an operation.
- `in_ready`  out  1  stage can accept; 1 only in IDLE.
- `in_rsa`  in  AW  source register for `ina`.
- `in_rsb`  in  AW  source register for `inb`.
- `in_rd`  in  AW  destination register.
- `ld_en`  in  1  direct register load strobe.
- `ld_addr`  in  AW  load address.
- `ld_data`  in  WIDTH  load data.
- `ina`  out  WIDTH  registered operand A to the logic unit.
- `inb`  out  WIDTH  registered operand B to the logic unit.
- `out`  in  WIDTH  combinational result from the logic unit.
- `done`  out  1  one-cycle pulse when a result is written back.
- `done_rd`  out  AW  destination of the completing operation.
- `done_data`  out  WIDTH  value being written back.
- `dbg_addr`  in  AW  debug read address.
- `dbg_data`  out  WIDTH  combinational read of `regs[dbg_addr]`.

## Operation

- Register file: NREG × WIDTH flops.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch `ina`←`regs[in_rsa]`, `inb`←`regs[in_rsb]`, and `rd_q`←`in_rd`; go to EXEC. Without `in_valid`, stay in IDLE.
  - EXEC: the logic unit evaluates. At the end of the cycle, `res_q`←`out`; go to WB.
  - WB: `done`=1, `done_rd`=`rd_q`, `done_data`=`res_q`. At the end of the cycle, `regs[rd_q]`←`res_q`; go to IDLE.
- `ina`/`inb` are held stable from the accept edge until the next accept; they do not change in EXEC, WB or IDLE.
- Loads:
  - `ld_en` writes `regs[ld_addr]`←`ld_data` in any state.
  - If `ld_en` coincides with the WB write to the same address, writeback wins and the load is dropped.
  - A load to a different address in the same cycle completes normally.
  - A load in the IDLE accept cycle to a source register is not seen by that operation; operands come from pre-edge register contents.
- `in_rsa`, `in_rsb` and `in_rd` may be equal; all three equal is legal and yields `regs[r]` OR-ed with itself.
- `in_valid` while not IDLE is ignored; the decoder must hold it until `in_ready`.
- No arithmetic and no width growth: `out` is WIDTH bits and is stored unchanged.

## Timing

- Reset (asynchronous, `rst_n`=0), effective immediately:
  - state=IDLE.
  - all regs=0.
  - `ina`=`inb`=0, `res_q`=0, `rd_q`=0.
  - `done`=0, `done_rd`=0, `done_data`=0.
  - `in_ready`=1, but no accept is possible while `rst_n`=0.
- Accept at edge N: EXEC during cycle N+1, `done` high during cycle N+2, register updated at the end of N+2, IDLE in cycle N+3.
- Latency: 3 cycles from accept to register update. Throughput: one operation per 3 cycles.
- With `in_valid` held high continuously, accepts occur at edges N, N+3, N+6, …
- The logic unit's combinational path must settle within one cycle, from the `ina`/`inb` launch edge to the EXEC capture edge.
- Reset mid-operation in EXEC or WB: the operation is abandoned, no writeback occurs, and `done` stays 0.
- `dbg_data` is combinational. It shows the new value the cycle after the write edge.

## Test plan

- Load R0=D4, R1=E3; issue rsa=0, rsb=1, rd=2:
  - `ina`=D4 and `inb`=E3 the cycle after accept.
  - `done` pulses 2 cycles after that with `done_rd`=2, `done_data`=F7.
  - `dbg_data`@R2=F7.
- Sequence with `in_valid` held continuously:
  - R0=FF, R1=DA → FF.
  - Then R0=D4, R3=00 → D4.
  - Then R0=D4, R1=23 → F7.
  - Accepts every 3 cycles, `in_ready` low for exactly 2 cycles each time, correct `done_data` each time.
- Collision: during WB to R2 (result F7), assert `ld_en` R2=55 → R2=F7. Repeat with `ld_addr`=3 → R2=F7 and R3=55.
- Operand stability: after issuing R0|R1, load R0=00 during EXEC → `ina` stays D4, result still F7, R0 reads 00.
- Reset in EXEC: assert `rst_n`=0 after accept →
  - `ina`/`inb`/`done` are 0 immediately.
  - All registers read 0.
  - After release, `in_ready`=1 and a new operation completes normally.
- Self-operand: R1=5A, rsa=rsb=rd=1 → `done_data`=5A, R1=5A.

Source files
------------

// File: rtl/logic_operand_stage.sv
// Operand staging/writeback around an external bitwise logic unit; 3 cycles accept-to-writeback.
// in_ready is high only in IDLE; in_valid outside IDLE is ignored, so the decoder holds it.
module logic_operand_stage #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rsa,
    input  logic [AW-1:0]    in_rsb,
    input  logic [AW-1:0]    in_rd,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] ina,
    output logic [WIDTH-1:0] inb,
    input  logic [WIDTH-1:0] out,
    output logic             done,
    output logic [AW-1:0]    done_rd,
    output logic [WIDTH-1:0] done_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] ina_q, inb_q, res_q;
    logic [AW-1:0]    rd_q;
    logic             accept;
    logic             wb_we;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign wb_we    = (state_q == S_WB);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ina_q   <= '0;
            inb_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            // Operands come from pre-edge contents, so a same-cycle load is not seen.
            if (accept) begin
                ina_q <= regs_q[in_rsa];
                inb_q <= regs_q[in_rsb];
                rd_q  <= in_rd;
            end
            if (state_q == S_EXEC) begin
                res_q <= out;
            end
        end
    end

    // Writeback has priority over a direct load to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_we && rd_q == AW'(i)) begin
                    regs_q[i] <= res_q;
                end else if (ld_en && ld_addr == AW'(i)) begin
                    regs_q[i] <= ld_data;
                end
            end
        end
    end

    assign ina       = ina_q;
    assign inb       = inb_q;
    assign done      = wb_we;
    assign done_rd   = wb_we ? rd_q  : '0;
    assign done_data = wb_we ? res_q : '0;
    assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_logic_operand_stage.sv
module tb_logic_operand_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_rsa, in_rsb, in_rd;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] ina, inb, out;
    logic       done;
    logic [1:0] done_rd;
    logic [7:0] done_data;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Stand-in for the external OR unit.
    assign out = ina | inb;

    logic_operand_stage #(.WIDTH(8), .NREG(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rsa(in_rsa), .in_rsb(in_rsb), .in_rd(in_rd),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ina(ina), .inb(inb), .out(out),
        .done(done), .done_rd(done_rd), .done_data(done_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct {
        logic [1:0] rsa;
        logic [1:0] rsb;
        logic [1:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic issue(input logic [1:0] rsa, input logic [1:0] rsb, input logic [1:0] rd);
        in_valid = 1'b1; in_rsa = rsa; in_rsb = rsb; in_rd = rd;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] rsa, input logic [1:0] rsb, input logic [1:0] rd,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        chk("ready_before", in_ready, 1'b1);
        issue(rsa, rsb, rd);
        chk("ina_exec", ina, a);
        chk("inb_exec", inb, b);
        chk("ready_exec", in_ready, 1'b0);
        chk("done_exec", done, 1'b0);
        tick();
        chk("done_wb", done, 1'b1);
        chk("done_rd", done_rd, rd);
        chk("done_data", done_data, exp);
        tick();
        chk("done_idle", done, 1'b0);
        chk("ready_idle", in_ready, 1'b1);
        chk("ina_hold", ina, a);
        read_reg("wb_reg", rd, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{rsa: 2'd0, rsb: 2'd1, rd: 2'd2, a: 8'hD4, b: 8'hE3, exp: 8'hF7};
        vecs[1] = '{rsa: 2'd0, rsb: 2'd1, rd: 2'd3, a: 8'hFF, b: 8'hDA, exp: 8'hFF};
        vecs[2] = '{rsa: 2'd0, rsb: 2'd3, rd: 2'd1, a: 8'hD4, b: 8'h00, exp: 8'hD4};
        vecs[3] = '{rsa: 2'd1, rsb: 2'd2, rd: 2'd1, a: 8'h3C, b: 8'h81, exp: 8'hBD};
        vecs[4] = '{rsa: 2'd3, rsb: 2'd2, rd: 2'd0, a: 8'h0F, b: 8'hF0, exp: 8'hFF};
        vecs[5] = '{rsa: 2'd3, rsb: 2'd0, rd: 2'd2, a: 8'h00, b: 8'h00, exp: 8'h00};

        rst_n = 1'b0; in_valid = 1'b0; in_rsa = '0; in_rsb = '0; in_rd = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        #2;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_ina", ina, 8'h00);
        chk("rst_inb", inb, 8'h00);
        chk("rst_done_data", done_data, 8'h00);
        for (int r = 0; r < 4; r++) read_reg("rst_reg", 2'(r), 8'h00);
        #5 rst_n = 1'b1;
        tick();

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            load(vecs[i].rsa, vecs[i].a);
            load(vecs[i].rsb, vecs[i].b);
            run_op(vecs[i].rsa, vecs[i].rsb, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-to-back with in_valid held; loads in EXEC feed the next operation
        load(2'd0, 8'hFF); load(2'd1, 8'hDA); load(2'd3, 8'h00);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_rsa = 2'd0; in_rd = 2'd2;
            in_rsb = (k == 1) ? 2'd3 : 2'd1;
            tick();
            chk("b2b_ready_exec", in_ready, 1'b0);
            ld_en = (k < 2); ld_addr = (k == 0) ? 2'd0 : 2'd1; ld_data = (k == 0) ? 8'hD4 : 8'h23;
            tick();
            ld_en = 1'b0;
            chk("b2b_ready_wb", in_ready, 1'b0);
            chk("b2b_done", done, 1'b1);
            chk("b2b_data", done_data, (k == 0) ? 8'hFF : (k == 1) ? 8'hD4 : 8'hF7);
            tick();
            chk("b2b_ready_idle", in_ready, 1'b1);
            chk("b2b_done_idle", done, 1'b0);
        end
        in_valid = 1'b0;
        tick();

        // Load colliding with writeback to the same register: writeback wins
        load(2'd2, 8'h00);
        issue(2'd0, 2'd1, 2'd2);
        tick();
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h55;
        tick();
        ld_en = 1'b0;
        read_reg("coll_same_r2", 2'd2, 8'hF7);

        // Load to a different register during writeback completes
        load(2'd2, 8'h00);
        issue(2'd0, 2'd1, 2'd2);
        tick();
        ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'h55;
        tick();
        ld_en = 1'b0;
        read_reg("coll_diff_r2", 2'd2, 8'hF7);
        read_reg("coll_diff_r3", 2'd3, 8'h55);

        // Operand stability: source overwritten during EXEC
        load(2'd1, 8'hE3);
        issue(2'd0, 2'd1, 2'd3);
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h00;
        tick();
        ld_en = 1'b0;
        chk("stab_ina", ina, 8'hD4);
        chk("stab_data", done_data, 8'hF7);
        tick();
        read_reg("stab_r3", 2'd3, 8'hF7);
        read_reg("stab_r0", 2'd0, 8'h00);

        // Load in the accept cycle is not seen by that operation
        load(2'd0, 8'hD4);
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h11;
        issue(2'd0, 2'd0, 2'd3);
        ld_en = 1'b0;
        chk("acc_ld_ina", ina, 8'hD4);
        tick();
        chk("acc_ld_data", done_data, 8'hD4);
        tick();
        read_reg("acc_ld_r0", 2'd0, 8'h11);

        // Reset during EXEC abandons the operation
        load(2'd0, 8'hD4); load(2'd1, 8'hE3); load(2'd2, 8'h00);
        issue(2'd0, 2'd1, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("rexec_ina", ina, 8'h00);
        chk("rexec_inb", inb, 8'h00);
        chk("rexec_done", done, 1'b0);
        chk("rexec_ready", in_ready, 1'b1);
        for (int r = 0; r < 4; r++) read_reg("rexec_reg", 2'(r), 8'h00);
        tick();
        chk("rexec_done_hold", done, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        chk("rexec_ready_post", in_ready, 1'b1);
        chk("rexec_done_post", done, 1'b0);
        read_reg("rexec_r2_post", 2'd2, 8'h00);

        // Self-operand after reset: all three addresses equal
        load(2'd1, 8'h5A);
        run_op(2'd1, 2'd1, 2'd1, 8'h5A, 8'h5A, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
